// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key classification for keypad_entry.
// Honors KEYPAD_BACKSPACE_EN: when defined, code D is backspace rather than a digit.
package keypad_pkg;

   localparam logic [3:0] KEY_NONE = 4'h0;
   localparam logic [3:0] KEY_BS   = 4'hD;
   localparam logic [3:0] KEY_CLR  = 4'hE;
   localparam logic [3:0] KEY_ENT  = 4'hF;

   localparam logic SEL_STATUS = 1'b1;
   localparam logic SEL_DATA   = 1'b0;

   typedef enum logic [2:0] {IDLE, STAT, SEL, CAP, EVAL} kp_state_e;

   function automatic logic is_digit(input logic [3:0] c);
`ifdef KEYPAD_BACKSPACE_EN
      return (c != KEY_NONE) && (c < KEY_BS);
`else
      return (c != KEY_NONE) && (c < KEY_CLR);
`endif
   endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Polled register bus between the keypad scanner and its consumer.
interface keypad_entry_if;
   logic [15:0] keyout;
   logic        statusordata;
   logic        ack;

   modport master (input keyout, output statusordata, output ack);
   modport slave  (output keyout, input statusordata, input ack);
endinterface

// File: rtl/keypad_key_qualifier.sv
// Debounce by consecutive identical polls plus a release-before-press rule.
import keypad_pkg::*;

module keypad_key_qualifier #(
   parameter int STABLE_POLLS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       eval,
   input  logic [3:0] code,
   output logic       key_accept,
   output logic [3:0] key_code
);

   localparam logic [3:0] SP = 4'(STABLE_POLLS);

   logic [3:0] last_code, stab_cnt, next_cnt;
   logic       armed, same, sat, reach;

   always_comb begin
      same     = (code == last_code);
      sat      = (stab_cnt == SP);
      next_cnt = !same ? 4'd1 : (sat ? stab_cnt : stab_cnt + 4'd1);
      // Only the poll where the count first hits the threshold counts.
      reach      = eval && (next_cnt == SP) && !(same && sat);
      key_accept = reach && (code != KEY_NONE) && armed;
      key_code   = code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_code <= KEY_NONE;
         stab_cnt  <= 4'd0;
         armed     <= 1'b0;
      end else if (eval) begin
         last_code <= code;
         stab_cnt  <= next_cnt;
         if (reach) begin
            if (code == KEY_NONE) armed <= 1'b1;
            else if (armed)       armed <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// Polls the keypad, qualifies presses and assembles a 4-digit hex entry.
// Honors KEYPAD_BACKSPACE_EN: when defined, code D deletes the newest digit.
import keypad_pkg::*;

module keypad_entry #(
   parameter int POLL_DIV     = 1024,
   parameter int STABLE_POLLS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   keypad_entry_if.master        kp,
   output logic [15:0]           entry,
   output logic [2:0]            digit_cnt,
   output logic                  overflow,
   output logic [15:0]           value,
   output logic                  value_valid
);

   localparam int PW = $clog2(POLL_DIV);

   kp_state_e   state;
   logic [PW-1:0] poll_cnt;
   logic        poll_tick;
   logic [3:0]  code_q;
   logic        key_accept;
   logic [3:0]  key_code;
   logic        unused_keyout;

   assign unused_keyout = ^kp.keyout[15:4];
   assign poll_tick     = (poll_cnt == PW'(POLL_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         poll_cnt <= '0;
      else if (poll_tick) poll_cnt <= '0;
      else                poll_cnt <= poll_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         kp.statusordata <= SEL_STATUS;
         kp.ack          <= 1'b0;
         code_q          <= KEY_NONE;
      end else begin
         case (state)
            IDLE: begin
               kp.statusordata <= SEL_STATUS;
               if (poll_tick) state <= STAT;
            end
            STAT: begin
               if (kp.keyout[0]) begin
                  state           <= SEL;
                  kp.statusordata <= SEL_DATA;
               end else begin
                  state <= IDLE;
               end
            end
            // Data select settles for a cycle before the word is taken.
            SEL: begin
               state  <= CAP;
               kp.ack <= 1'b1;
            end
            CAP: begin
               code_q          <= kp.keyout[3:0];
               kp.ack          <= 1'b0;
               kp.statusordata <= SEL_STATUS;
               state           <= EVAL;
            end
            EVAL:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   keypad_key_qualifier #(.STABLE_POLLS(STABLE_POLLS)) u_qual (
      .clk        (clk),
      .rst_n      (rst_n),
      .eval       (state == EVAL),
      .code       (code_q),
      .key_accept (key_accept),
      .key_code   (key_code)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry       <= 16'h0;
         digit_cnt   <= 3'd0;
         overflow    <= 1'b0;
         value       <= 16'h0;
         value_valid <= 1'b0;
      end else begin
         value_valid <= 1'b0;
         if (key_accept) begin
            if (is_digit(key_code)) begin
               if (digit_cnt < 3'd4) begin
                  entry     <= {entry[11:0], key_code};
                  digit_cnt <= digit_cnt + 3'd1;
               end else begin
                  overflow <= 1'b1;
               end
            end else if (key_code == KEY_CLR) begin
               entry     <= 16'h0;
               digit_cnt <= 3'd0;
               overflow  <= 1'b0;
            end else if (key_code == KEY_ENT) begin
               if (digit_cnt != 3'd0) begin
                  value       <= entry;
                  value_valid <= 1'b1;
                  entry       <= 16'h0;
                  digit_cnt   <= 3'd0;
                  overflow    <= 1'b0;
               end
`ifdef KEYPAD_BACKSPACE_EN
            end else if (key_code == KEY_BS) begin
               if (digit_cnt != 3'd0) begin
                  entry     <= {4'h0, entry[15:4]};
                  digit_cnt <= digit_cnt - 3'd1;
                  overflow  <= 1'b0;
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural keypad register model.
module tb_keypad_entry;

   localparam int PD   = 8;
   localparam int HOLD = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ready = 1'b1;
   logic [3:0]  kcode = 4'h0;
   logic [15:0] entry, value;
   logic [2:0]  digit_cnt;
   logic        overflow, value_valid;

   int checks = 0, errors = 0;
   int ack_cnt = 0, ack_bad = 0, sel0_cnt = 0, vv_cnt = 0, vv_wide = 0;
   logic ack_prev = 1'b0, vv_prev = 1'b0;

   always #5 clk = ~clk;

   keypad_entry_if kif();
   assign kif.keyout = kif.statusordata ? {15'h0, ready} : {12'h0, kcode};

   keypad_entry #(.POLL_DIV(PD), .STABLE_POLLS(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .kp          (kif),
      .entry       (entry),
      .digit_cnt   (digit_cnt),
      .overflow    (overflow),
      .value       (value),
      .value_valid (value_valid)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (kif.ack) ack_cnt++;
         if (kif.ack && (kif.statusordata || ack_prev)) ack_bad++;
         if (!kif.statusordata) sel0_cnt++;
         if (value_valid) vv_cnt++;
         if (value_valid && vv_prev) vv_wide++;
      end
      ack_prev = kif.ack;
      vv_prev  = value_valid;
   end

   task automatic polls(input int n);
      repeat (n * PD) @(posedge clk);
   endtask

   task automatic press(input logic [3:0] k);
      kcode = k;
      polls(HOLD);
      kcode = 4'h0;
      polls(HOLD);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (kif.statusordata !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b exp 1", kif.statusordata); end
      checks++; if (kif.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", kif.ack); end
      checks++; if ({entry, value, digit_cnt, overflow, value_valid} !== 37'h0) begin errors++;
         $display("FAIL reset_outputs: entry %h value %h cnt %0d ov %b vv %b exp all 0", entry, value, digit_cnt, overflow, value_valid); end
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
   endtask

   task automatic test_first_key;
      int a0;
      a0 = ack_cnt;
      kcode = 4'h0;
      polls(HOLD);
      press(4'h5);
      checks++; if (entry !== 16'h0005) begin errors++; $display("FAIL first_entry: got %h exp 0005", entry); end
      checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL first_cnt: got %0d exp 1", digit_cnt); end
      checks++; if (ack_cnt - a0 !== 3 * HOLD) begin errors++; $display("FAIL ack_per_poll: got %0d exp %0d", ack_cnt - a0, 3 * HOLD); end
      checks++; if (ack_bad !== 0) begin errors++; $display("FAIL ack_shape: got %0d bad exp 0", ack_bad); end
      checks++; if (vv_cnt !== 0) begin errors++; $display("FAIL first_no_vv: got %0d exp 0", vv_cnt); end
   endtask

   task automatic test_commit;
      int v0;
      logic [3:0] seq [4];
      seq = '{4'h1, 4'h2, 4'h3, 4'hA};
      press(4'hE);
      foreach (seq[i]) press(seq[i]);
      checks++; if (entry !== 16'h123A) begin errors++; $display("FAIL commit_entry: got %h exp 123a", entry); end
      v0 = vv_cnt;
      press(4'hF);
      checks++; if (value !== 16'h123A) begin errors++; $display("FAIL commit_value: got %h exp 123a", value); end
      checks++; if (vv_cnt - v0 !== 1) begin errors++; $display("FAIL commit_vv_pulses: got %0d exp 1", vv_cnt - v0); end
      checks++; if (vv_wide !== 0) begin errors++; $display("FAIL commit_vv_width: got %0d wide exp 0", vv_wide); end
      checks++; if ({entry, digit_cnt} !== 19'h0) begin errors++; $display("FAIL commit_clear: entry %h cnt %0d exp 0", entry, digit_cnt); end
   endtask

   task automatic test_overflow;
      int v0;
      v0 = vv_cnt;
      for (int d = 1; d <= 5; d++) press(4'(d));
      checks++; if (entry !== 16'h1234) begin errors++; $display("FAIL ovf_entry: got %h exp 1234", entry); end
      checks++; if (overflow !== 1'b1 || digit_cnt !== 3'd4) begin errors++; $display("FAIL ovf_flag: ov %b cnt %0d exp 1 4", overflow, digit_cnt); end
      press(4'hE);
      checks++; if ({entry, digit_cnt, overflow} !== 20'h0) begin errors++; $display("FAIL clr_state: entry %h cnt %0d ov %b exp 0", entry, digit_cnt, overflow); end
      checks++; if (vv_cnt !== v0) begin errors++; $display("FAIL clr_no_vv: got %0d exp %0d", vv_cnt, v0); end
   endtask

   task automatic test_hold_glitch;
      kcode = 4'h7;
      polls(20);
      kcode = 4'h0;
      polls(HOLD);
      @(negedge clk);
      checks++; if (entry !== 16'h0007 || digit_cnt !== 3'd1) begin errors++; $display("FAIL hold_single: entry %h cnt %0d exp 0007 1", entry, digit_cnt); end
      for (int i = 0; i < 10; i++) begin
         kcode = 4'h7; polls(1);
         kcode = 4'h0; polls(1);
      end
      @(negedge clk);
      checks++; if (entry !== 16'h0007) begin errors++; $display("FAIL glitch_ignored: got %h exp 0007", entry); end
      press(4'hE);
      checks++; if (entry !== 16'h0000) begin errors++; $display("FAIL glitch_then_clr: got %h exp 0000", entry); end
   endtask

   task automatic test_enter_empty;
      int v0;
      v0 = vv_cnt;
      press(4'hF);
      checks++; if (vv_cnt !== v0) begin errors++; $display("FAIL empty_ent_vv: got %0d exp %0d", vv_cnt, v0); end
      checks++; if (value !== 16'h123A) begin errors++; $display("FAIL empty_ent_value: got %h exp 123a", value); end
   endtask

   task automatic test_backspace;
      press(4'h1);
      press(4'h2);
      press(4'hD);
`ifdef KEYPAD_BACKSPACE_EN
      checks++; if (entry !== 16'h0001 || digit_cnt !== 3'd1) begin errors++; $display("FAIL bs_entry: entry %h cnt %0d exp 0001 1", entry, digit_cnt); end
`else
      checks++; if (entry !== 16'h012D || digit_cnt !== 3'd3) begin errors++; $display("FAIL d_digit: entry %h cnt %0d exp 012d 3", entry, digit_cnt); end
`endif
   endtask

   task automatic test_not_ready;
      int a0, s0;
      a0 = ack_cnt;
      s0 = sel0_cnt;
      ready = 1'b0;
      kcode = 4'h9;
      polls(HOLD);
      @(negedge clk);
      checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL notready_ack: got %0d acks exp 0", ack_cnt - a0); end
      checks++; if (sel0_cnt !== s0) begin errors++; $display("FAIL notready_sel: got %0d data cycles exp 0", sel0_cnt - s0); end
      kcode = 4'h0;
      ready = 1'b1;
   endtask

   task automatic test_reset_cap;
      bit found = 1'b0;
      kcode = 4'h3;
      for (int i = 0; i < 4 * PD && !found; i++) begin
         @(negedge clk);
         if (kif.ack) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL cap_wait: got no ack exp ack within %0d cycles", 4 * PD);
      end else begin
         rst_n = 1'b0;
         #1;
         checks++; if (kif.ack !== 1'b0) begin errors++; $display("FAIL cap_rst_ack: got %b exp 0", kif.ack); end
         checks++; if (kif.statusordata !== 1'b1) begin errors++; $display("FAIL cap_rst_sel: got %b exp 1", kif.statusordata); end
         checks++; if ({entry, value, digit_cnt, overflow, value_valid} !== 37'h0) begin errors++;
            $display("FAIL cap_rst_outputs: entry %h value %h cnt %0d ov %b vv %b exp all 0", entry, value, digit_cnt, overflow, value_valid); end
      end
      kcode = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_key();
      test_commit();
      test_overflow();
      test_hold_glitch();
      test_enter_empty();
      test_backspace();
      test_not_ready();
      test_reset_cap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
